// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Shares the single MMU port between the instruction-fetch (IF)
//             and data-memory (MEM) requesters. MEM has fixed priority over
//             IF. Each access holds the MMU strobes for WAIT_CYCLES cycles,
//             captures read data, and returns a one-cycle ready pulse to the
//             granted side. The stall output freezes the pipeline while an
//             access is pending.
//  Ports    : clk, rst                       - clock, async active-high reset
//             if_req/if_addr                 - IF word-read request
//             if_rdata/if_ready              - IF read data and completion
//             mem_req/mem_we/mem_bytemode/
//             mem_addr/mem_wdata             - MEM access request
//             mem_rdata/mem_ready            - MEM read data and completion
//             mmu_read/mmu_write/mmu_addr/
//             mmu_wdata/mmu_bytemode         - registered MMU command bus
//             mmu_rdata                      - MMU read data
//             stall                          - pipeline freeze (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic        mem_bytemode,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mmu_read,
  output logic        mmu_write,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_wdata,
  output logic        mmu_bytemode,
  input  logic [31:0] mmu_rdata,
  output logic        stall
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_IF   = 2'd1;
  localparam logic [1:0] G_MEM  = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        byte_q, byte_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_rdy_q, if_rdy_d;
  logic        mem_rdy_q, mem_rdy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    byte_d      = byte_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    // Ready outputs are single-cycle pulses, so they default low.
    if_rdy_d    = 1'b0;
    mem_rdy_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          grant_d = G_MEM;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          byte_d  = mem_bytemode;
          wr_d    = mem_we;
          rd_d    = ~mem_we;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end else if (if_req) begin
          grant_d = G_IF;
          addr_d  = if_addr;
          wdata_d = 32'd0;
          byte_d  = 1'b0;
          wr_d    = 1'b0;
          rd_d    = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end else begin
          grant_d = G_NONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end

      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Only reads update a data register; writes leave mem_rdata alone.
          if (rd_q) begin
            if (grant_q == G_IF) if_rdata_d  = mmu_rdata;
            else                 mem_rdata_d = mmu_rdata;
          end
          if (grant_q == G_IF) if_rdy_d  = 1'b1;
          else                 mem_rdy_d = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      grant_q     <= G_NONE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      byte_q      <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_rdy_q    <= 1'b0;
      mem_rdy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      byte_q      <= byte_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_rdy_q    <= if_rdy_d;
      mem_rdy_q   <= mem_rdy_d;
    end
  end

  assign mmu_read     = rd_q;
  assign mmu_write    = wr_q;
  assign mmu_addr     = addr_q;
  assign mmu_wdata    = wdata_q;
  assign mmu_bytemode = byte_q;
  assign if_rdata     = if_rdata_q;
  assign mem_rdata    = mem_rdata_q;
  assign if_ready     = if_rdy_q;
  assign mem_ready    = mem_rdy_q;

  assign stall = (if_req & ~if_rdy_q) | (mem_req & ~mem_rdy_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Directed self-checking bench for mem_bus_arbiter. One instance
//             uses WAIT_CYCLES=2, a second uses WAIT_CYCLES=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WAIT_CYCLES = 2 instance
  logic        if_req, mem_req, mem_we, mem_bytemode;
  logic [31:0] if_addr, mem_addr, mem_wdata, mmu_rdata;
  logic [31:0] if_rdata, mem_rdata, mmu_addr, mmu_wdata;
  logic        if_ready, mem_ready, mmu_read, mmu_write, mmu_bytemode, stall;

  // WAIT_CYCLES = 1 instance
  logic        if_req1, mem_req1, mem_we1, mem_bytemode1;
  logic [31:0] if_addr1, mem_addr1, mem_wdata1, mmu_rdata1;
  logic [31:0] if_rdata1, mem_rdata1, mmu_addr1, mmu_wdata1;
  logic        if_ready1, mem_ready1, mmu_read1, mmu_write1, mmu_bytemode1, stall1;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_bytemode(mem_bytemode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr),
    .mmu_wdata(mmu_wdata), .mmu_bytemode(mmu_bytemode), .mmu_rdata(mmu_rdata),
    .stall(stall)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_bytemode(mem_bytemode1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .mem_ready(mem_ready1),
    .mmu_read(mmu_read1), .mmu_write(mmu_write1), .mmu_addr(mmu_addr1),
    .mmu_wdata(mmu_wdata1), .mmu_bytemode(mmu_bytemode1), .mmu_rdata(mmu_rdata1),
    .stall(stall1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; mem_req = 0; mem_we = 0; mem_bytemode = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; mmu_rdata = 0;
    if_req1 = 0; mem_req1 = 0; mem_we1 = 0; mem_bytemode1 = 0;
    if_addr1 = 0; mem_addr1 = 0; mem_wdata1 = 0; mmu_rdata1 = 0;
    step(); step();

    // Reset state
    chk1("rst_read", mmu_read, 1'b0);
    chk1("rst_write", mmu_write, 1'b0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_mem_ready", mem_ready, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_bytemode", mmu_bytemode, 1'b0);
    chk("rst_addr", mmu_addr, 32'h0);
    chk("rst_wdata", mmu_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    step();

    // T1: single IF read
    if_req = 1; if_addr = 32'h8000_0004; mmu_rdata = 32'h2402_0001;
    #1;
    chk1("t1_stall_idle", stall, 1'b1);
    chk1("t1_read_idle", mmu_read, 1'b0);
    step();
    chk1("t1_read_c1", mmu_read, 1'b1);
    chk("t1_addr", mmu_addr, 32'h8000_0004);
    chk1("t1_ready_c1", if_ready, 1'b0);
    step();
    chk1("t1_read_c2", mmu_read, 1'b1);
    chk1("t1_stall_c2", stall, 1'b1);
    step();
    chk1("t1_read_done", mmu_read, 1'b0);
    chk1("t1_if_ready", if_ready, 1'b1);
    chk("t1_if_rdata", if_rdata, 32'h2402_0001);
    chk1("t1_stall_done", stall, 1'b0);
    step();
    chk1("t1_ready_gone", if_ready, 1'b0);
    if_req = 0;
    step();
    chk1("t1_read_idle2", mmu_read, 1'b0);

    // T2: simultaneous requests, MEM wins
    mem_req = 1; if_req = 1; mem_we = 0; mem_addr = 32'h8040_0000;
    if_addr = 32'h0000_0010; mmu_rdata = 32'h1122_3344;
    step();
    chk("t2_addr_mem", mmu_addr, 32'h8040_0000);
    chk1("t2_read", mmu_read, 1'b1);
    chk1("t2_write", mmu_write, 1'b0);
    step();
    step();
    chk1("t2_mem_ready", mem_ready, 1'b1);
    chk1("t2_if_ready_lo", if_ready, 1'b0);
    chk("t2_mem_rdata", mem_rdata, 32'h1122_3344);
    chk1("t2_stall_if_pending", stall, 1'b1);
    step();
    chk1("t2_mem_ready_gone", mem_ready, 1'b0);
    mem_req = 0; mmu_rdata = 32'h5566_7788;
    step();
    chk("t2_addr_if", mmu_addr, 32'h0000_0010);
    chk1("t2_read_if", mmu_read, 1'b1);
    step();
    chk1("t2_if_ready_early", if_ready, 1'b0);
    step();
    chk1("t2_if_ready", if_ready, 1'b1);
    chk("t2_if_rdata", if_rdata, 32'h5566_7788);
    chk("t2_mem_rdata_kept", mem_rdata, 32'h1122_3344);
    step();
    if_req = 0;

    // T3: MEM byte write
    mem_req = 1; mem_we = 1; mem_bytemode = 1; mem_addr = 32'h8040_0003;
    mem_wdata = 32'h0000_00AB; mmu_rdata = 32'hDEAD_BEEF;
    step();
    chk1("t3_write_c1", mmu_write, 1'b1);
    chk1("t3_read_c1", mmu_read, 1'b0);
    chk1("t3_byte_c1", mmu_bytemode, 1'b1);
    chk("t3_wdata_c1", mmu_wdata, 32'h0000_00AB);
    chk("t3_addr_c1", mmu_addr, 32'h8040_0003);
    step();
    chk1("t3_write_c2", mmu_write, 1'b1);
    chk("t3_wdata_c2", mmu_wdata, 32'h0000_00AB);
    chk("t3_addr_c2", mmu_addr, 32'h8040_0003);
    step();
    chk1("t3_mem_ready", mem_ready, 1'b1);
    chk1("t3_write_done", mmu_write, 1'b0);
    chk("t3_mem_rdata_kept", mem_rdata, 32'h1122_3344);
    step();
    mem_req = 0; mem_we = 0; mem_bytemode = 0;

    // T4: back-to-back IF reads with if_req held
    if_req = 1; if_addr = 32'h0; mmu_rdata = 32'h0000_00A0;
    step();
    chk1("t4_read_a", mmu_read, 1'b1);
    chk("t4_addr_a", mmu_addr, 32'h0);
    step();
    step();
    chk1("t4_ready_a", if_ready, 1'b1);
    chk("t4_rdata_a", if_rdata, 32'h0000_00A0);
    chk1("t4_read_done", mmu_read, 1'b0);
    step();
    chk1("t4_read_idle", mmu_read, 1'b0);
    chk1("t4_ready_idle", if_ready, 1'b0);
    if_addr = 32'h4; mmu_rdata = 32'h0000_00A4;
    step();
    chk1("t4_read_b", mmu_read, 1'b1);
    chk("t4_addr_b", mmu_addr, 32'h4);
    step();
    step();
    chk1("t4_ready_b", if_ready, 1'b1);
    chk("t4_rdata_b", if_rdata, 32'h0000_00A4);
    step();
    if_req = 0;

    // T5: asynchronous reset mid-access
    mem_req = 1; mem_addr = 32'h0000_0200; mmu_rdata = 32'h0000_0033;
    step();
    chk1("t5_read_pre", mmu_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("t5_read_async", mmu_read, 1'b0);
    chk1("t5_write_async", mmu_write, 1'b0);
    chk("t5_mem_rdata_clr", mem_rdata, 32'h0);
    chk("t5_if_rdata_clr", if_rdata, 32'h0);
    mem_req = 0;
    step();
    rst = 1'b0;
    step();
    chk1("t5_no_ready_a", mem_ready, 1'b0);
    step();
    chk1("t5_no_ready_b", mem_ready, 1'b0);
    chk1("t5_read_idle", mmu_read, 1'b0);
    if_req = 1; if_addr = 32'h0000_0020; mmu_rdata = 32'h0000_0077;
    step();
    chk1("t5_read_new", mmu_read, 1'b1);
    step();
    step();
    chk1("t5_if_ready", if_ready, 1'b1);
    chk("t5_if_rdata", if_rdata, 32'h0000_0077);
    step();
    if_req = 0;

    // T6: WAIT_CYCLES=1 mem read
    mem_req1 = 1; mem_addr1 = 32'h0000_0100; mmu_rdata1 = 32'h0000_0099;
    step();
    chk1("t6_read_c1", mmu_read1, 1'b1);
    chk1("t6_ready_c1", mem_ready1, 1'b0);
    step();
    chk1("t6_mem_ready", mem_ready1, 1'b1);
    chk1("t6_read_done", mmu_read1, 1'b0);
    chk("t6_mem_rdata", mem_rdata1, 32'h0000_0099);
    step();
    mem_req1 = 0;
    chk1("t6_ready_gone", mem_ready1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
